qtree_int_serializer: RTL and testbench



---
 rtl/qtree_int_serializer.sv | 199 +++++++++++++++++++
 tb/tb_qtree_int_serializer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtree_int_serializer.sv
// qtree_int_serializer: walks a heap-resident QTree_Int depth-first from a
// root pointer and streams every node in post-order. For each node, the
// children are emitted last-to-first and the parent follows them. A
// stack-based loader on the far side therefore rebuilds the tree with child0
// on top.
module qtree_int_serializer #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 64,
    parameter int SP_W        = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W:0]   root_d,
    output logic              root_r,
    output logic              heap_req_valid,
    input  logic              heap_req_ready,
    output logic [ADDR_W-1:0] heap_req_addr,
    input  logic              heap_resp_valid,
    input  logic [65:0]       heap_resp_data,
    output logic [66:0]       o_QTree_Int_tdata,
    output logic              o_QTree_Int_tvalid,
    output logic              o_QTree_Int_tlast,
    input  logic              o_QTree_Int_tready,
    output logic              done_d,
    input  logic              done_r,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_VISIT,
        S_EMIT,
        S_DONE
    } state_t;

    // sp is one bit wider than a stack index so that "full" is representable.
    localparam logic [SP_W:0] SP_FULL = (SP_W+1)'(STACK_DEPTH);
    localparam logic [SP_W:0] SP_ONE  = (SP_W+1)'(1);
    localparam logic [1:0]    TAG_QNODE = 2'd2;

    state_t        state_q, state_d;
    logic [SP_W:0] sp_q, sp_d;
    logic          err_q, err_d;

    // Traversal stack, split per field so each field has a single write port.
    logic [ADDR_W-1:0] stk_addr_q [STACK_DEPTH];
    logic [65:0]       stk_pay_q  [STACK_DEPTH];
    logic [2:0]        stk_idx_q  [STACK_DEPTH];

    logic              addr_we;
    logic [SP_W-1:0]   addr_wptr;
    logic [ADDR_W-1:0] addr_wdata;
    logic              pay_we;
    logic              idx_we;
    logic [2:0]        idx_wdata;

    logic [SP_W-1:0]   top_ptr;
    logic [SP_W-1:0]   push_ptr;
    logic [ADDR_W-1:0] top_addr;
    logic [65:0]       top_pay;
    logic [2:0]        top_idx;

    // The idx field counts how many children have been visited so far. The
    // child taken on each visit is slot (3-idx), so the last child goes first.
    function automatic logic [ADDR_W-1:0] child_slot(input logic [65:0] pay,
                                                     input logic [1:0]  idx);
        logic [15:0] slot;
        case (idx)
            2'd0:    slot = pay[65:50];
            2'd1:    slot = pay[49:34];
            2'd2:    slot = pay[33:18];
            default: slot = pay[17:2];
        endcase
        return ADDR_W'(slot);
    endfunction

    assign top_ptr  = SP_W'(sp_q - SP_ONE);
    assign push_ptr = SP_W'(sp_q);
    assign top_addr = stk_addr_q[top_ptr];
    assign top_pay  = stk_pay_q[top_ptr];
    assign top_idx  = stk_idx_q[top_ptr];
    assign err      = err_q;

    // Next-state, stack write controls and handshake outputs.
    always_comb begin
        state_d            = state_q;
        sp_d               = sp_q;
        err_d              = err_q;
        addr_we            = 1'b0;
        addr_wptr          = push_ptr;
        addr_wdata         = root_d[ADDR_W:1];
        pay_we             = 1'b0;
        idx_we             = 1'b0;
        idx_wdata          = 3'd0;
        root_r             = 1'b0;
        heap_req_valid     = 1'b0;
        heap_req_addr      = '0;
        o_QTree_Int_tvalid = 1'b0;
        o_QTree_Int_tdata  = '0;
        o_QTree_Int_tlast  = 1'b0;
        done_d             = 1'b0;

        case (state_q)
            S_IDLE: begin
                root_r = 1'b1;
                if (root_d[0]) begin
                    // A new tree always starts from an empty stack, even after
                    // an overflow abort left entries behind.
                    addr_we    = 1'b1;
                    addr_wptr  = '0;
                    addr_wdata = root_d[ADDR_W:1];
                    sp_d       = SP_ONE;
                    err_d      = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                heap_req_valid = 1'b1;
                heap_req_addr  = top_addr;
                if (heap_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (heap_resp_valid) begin
                    pay_we    = 1'b1;
                    idx_we    = 1'b1;
                    idx_wdata = 3'd0;
                    state_d   = S_VISIT;
                end
            end
            S_VISIT: begin
                if (top_pay[1:0] == TAG_QNODE && !top_idx[2]) begin
                    idx_we    = 1'b1;
                    idx_wdata = top_idx + 3'd1;
                    if (sp_q == SP_FULL) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_we    = 1'b1;
                        addr_wptr  = push_ptr;
                        addr_wdata = child_slot(top_pay, top_idx[1:0]);
                        sp_d       = sp_q + SP_ONE;
                        state_d    = S_REQ;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                o_QTree_Int_tvalid = 1'b1;
                o_QTree_Int_tdata  = {top_pay, 1'b0};
                o_QTree_Int_tlast  = (sp_q == SP_ONE);
                if (o_QTree_Int_tready) begin
                    sp_d    = sp_q - SP_ONE;
                    state_d = (sp_q == SP_ONE) ? S_DONE : S_VISIT;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                if (done_r) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register; reset abandons any traversal in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Stack storage writes; contents are meaningless while sp is zero.
    always_ff @(posedge clk) begin
        if (addr_we) begin
            stk_addr_q[addr_wptr] <= addr_wdata;
        end
        if (pay_we) begin
            stk_pay_q[top_ptr] <= heap_resp_data;
        end
        if (idx_we) begin
            stk_idx_q[top_ptr] <= idx_wdata;
        end
    end

endmodule

// File: tb/tb_qtree_int_serializer.sv
// Bench for qtree_int_serializer: a default-size instance for the traversal
// vectors and a two-entry-stack instance for the overflow abort.
module tb_qtree_int_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [16:0] root_d, root_d2;
    logic        root_r, root_r2;
    logic        hq_v, hq_r, hq_v2, hq_r2;
    logic [15:0] hq_a, hq_a2;
    logic        hs_v, hs_v2;
    logic [65:0] hs_d, hs_d2;
    logic [66:0] t_d, t_d2;
    logic        t_v, t_l, t_r, t_v2, t_l2, t_r2;
    logic        done_d, done_r, done_d2, done_r2;
    logic        err, err2;

    qtree_int_serializer dut (
        .clk(clk), .reset(reset), .root_d(root_d), .root_r(root_r),
        .heap_req_valid(hq_v), .heap_req_ready(hq_r), .heap_req_addr(hq_a),
        .heap_resp_valid(hs_v), .heap_resp_data(hs_d),
        .o_QTree_Int_tdata(t_d), .o_QTree_Int_tvalid(t_v),
        .o_QTree_Int_tlast(t_l), .o_QTree_Int_tready(t_r),
        .done_d(done_d), .done_r(done_r), .err(err)
    );

    qtree_int_serializer #(.ADDR_W(16), .STACK_DEPTH(2), .SP_W(1)) dut2 (
        .clk(clk), .reset(reset), .root_d(root_d2), .root_r(root_r2),
        .heap_req_valid(hq_v2), .heap_req_ready(hq_r2), .heap_req_addr(hq_a2),
        .heap_resp_valid(hs_v2), .heap_resp_data(hs_d2),
        .o_QTree_Int_tdata(t_d2), .o_QTree_Int_tvalid(t_v2),
        .o_QTree_Int_tlast(t_l2), .o_QTree_Int_tready(t_r2),
        .done_d(done_d2), .done_r(done_r2), .err(err2)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [65:0] mem [256];

    function automatic logic [65:0] qval(input logic [31:0] v);
        return {32'h0, v, 2'd1};
    endfunction

    function automatic logic [65:0] qnode(input logic [15:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0, 2'd2};
    endfunction

    function automatic logic [143:0] l9(input logic [15:0] a0 = 0, a1 = 0, a2 = 0,
                                        a3 = 0, a4 = 0, a5 = 0, a6 = 0,
                                        a7 = 0, a8 = 0);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    typedef struct packed {
        logic [15:0]  root;
        logic         stall;
        logic [3:0]   n;
        logic [143:0] beat;
        logic [3:0]   nr;
        logic [143:0] rd;
    } vec_t;
    vec_t vec [4];

    // Heap responder and stream monitor for the main instance.
    int          tr_mode = 0;
    int          stop_n  = 0;
    bit          hstall  = 0;
    logic [15:0] reads [$];
    logic [66:0] bdata [$];
    logic        blast [$];
    bit          pend = 0;
    logic [65:0] pend_d;
    bit          hold_v = 0;
    logic [66:0] hold_d;
    logic        hold_l;
    bit          first_seen = 0;
    int          first_cyc = 0;

    always @(negedge clk) begin
        hs_v = pend;
        hs_d = pend ? pend_d : 66'h0;
        pend = 0;
        hq_r = hstall ? ($urandom_range(0, 2) != 0) : 1'b1;
        case (tr_mode)
            0:       t_r = 1'b1;
            1:       t_r = ($urandom_range(0, 2) != 0);
            default: t_r = (bdata.size() < stop_n);
        endcase
        #1;
        if (hq_v && hq_r) begin
            reads.push_back(hq_a);
            pend   = 1;
            pend_d = mem[hq_a[7:0]];
        end
        if (!t_v) begin
            hold_v = 0;
        end else begin
            if (!first_seen) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (hold_v) begin
                chk("stall_tdata", t_d, hold_d);
                chk("stall_tlast", t_l, hold_l);
            end
            if (t_r) begin
                bdata.push_back(t_d);
                blast.push_back(t_l);
                hold_v = 0;
            end else begin
                hold_v = 1;
                hold_d = t_d;
                hold_l = t_l;
            end
        end
    end

    // Heap responder and beat counter for the small-stack instance.
    logic [15:0] reads2 [$];
    bit          pend2 = 0;
    logic [65:0] pend_d2;
    int          nb2 = 0;
    int          nl2 = 0;
    logic [66:0] last2;

    always @(negedge clk) begin
        hs_v2 = pend2;
        hs_d2 = pend2 ? pend_d2 : 66'h0;
        pend2 = 0;
        #1;
        if (hq_v2) begin
            reads2.push_back(hq_a2);
            pend2   = 1;
            pend_d2 = mem[hq_a2[7:0]];
        end
        if (t_v2) begin
            nb2++;
            if (t_l2) nl2++;
            last2 = t_d2;
        end
    end

    task automatic run1(input logic [15:0] root, output bit ok_done, output int lat);
        reads.delete();
        bdata.delete();
        blast.delete();
        first_seen = 0;
        ok_done = 0;
        @(negedge clk);
        root_d = {root, 1'b1};
        lat = cyc;
        @(posedge clk);
        #1 root_d = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            if (done_d) begin
                ok_done = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        lat = first_cyc - lat;
    endtask

    task automatic check_vec(input int k, input bit dn);
        logic [15:0] ea;
        chk($sformatf("done_seen[%0d]", k), dn, 1'b1);
        chk($sformatf("err[%0d]", k), err, 1'b0);
        chk($sformatf("beats[%0d]", k), bdata.size(), vec[k].n);
        for (int i = 0; i < int'(vec[k].n); i++) begin
            if (i < bdata.size()) begin
                ea = vec[k].beat[16*i +: 16];
                chk($sformatf("tdata[%0d.%0d]", k, i), bdata[i], {mem[ea[7:0]], 1'b0});
                chk($sformatf("tlast[%0d.%0d]", k, i), blast[i], (i == int'(vec[k].n) - 1));
            end
        end
        chk($sformatf("nreads[%0d]", k), reads.size(), vec[k].nr);
        for (int i = 0; i < int'(vec[k].nr); i++) begin
            if (i < reads.size()) begin
                chk($sformatf("rdaddr[%0d.%0d]", k, i), reads[i], vec[k].rd[16*i +: 16]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        bit          dn;
        bit          found;
        int          lat;
        logic [66:0] b0;

        for (int i = 0; i < 256; i++) mem[i] = 66'h0;
        mem[8'h10] = qval(32'd42);
        mem[8'h01] = qnode(16'h2, 16'h3, 16'h4, 16'h5);
        mem[8'h02] = qval(32'd1);
        mem[8'h03] = qval(32'd2);
        mem[8'h04] = qval(32'd3);
        mem[8'h05] = qval(32'd4);
        mem[8'h20] = qnode(16'h21, 16'h22, 16'h23, 16'h24);
        mem[8'h21] = qnode(16'h30, 16'h31, 16'h32, 16'h33);
        mem[8'h22] = qval(32'd20);
        mem[8'h23] = qval(32'd21);
        mem[8'h24] = qval(32'd22);
        mem[8'h30] = qval(32'd10);
        mem[8'h31] = qval(32'd11);
        mem[8'h32] = qval(32'd12);
        mem[8'h33] = qval(32'd13);
        mem[8'h40] = qnode(16'h10, 16'h10, 16'h10, 16'h41);
        mem[8'h41] = qnode(16'h10, 16'h10, 16'h10, 16'h42);
        mem[8'h42] = qval(32'd7);

        vec[0] = '{root: 16'h10, stall: 1'b0, n: 4'd1, beat: l9(16'h10),
                   nr: 4'd1, rd: l9(16'h10)};
        vec[1] = '{root: 16'h01, stall: 1'b0, n: 4'd5,
                   beat: l9(16'h5, 16'h4, 16'h3, 16'h2, 16'h1),
                   nr: 4'd5, rd: l9(16'h1, 16'h5, 16'h4, 16'h3, 16'h2)};
        vec[2] = '{root: 16'h20, stall: 1'b0, n: 4'd9,
                   beat: l9(16'h24, 16'h23, 16'h22, 16'h33, 16'h32, 16'h31, 16'h30, 16'h21, 16'h20),
                   nr: 4'd9,
                   rd: l9(16'h20, 16'h24, 16'h23, 16'h22, 16'h21, 16'h33, 16'h32, 16'h31, 16'h30)};
        vec[3] = '{root: 16'h01, stall: 1'b1, n: 4'd5,
                   beat: l9(16'h5, 16'h4, 16'h3, 16'h2, 16'h1),
                   nr: 4'd5, rd: l9(16'h1, 16'h5, 16'h4, 16'h3, 16'h2)};

        reset   = 1'b1;
        root_d  = '0;
        root_d2 = '0;
        done_r  = 1'b1;
        done_r2 = 1'b1;
        hq_r2   = 1'b1;
        t_r2    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_root_r", root_r, 1'b1);
        chk("rst_tvalid", t_v, 1'b0);
        chk("rst_req", hq_v, 1'b0);
        chk("rst_done", done_d, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_tdata", t_d, 67'h0);
        chk("rst_sp", dut.sp_q, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) begin
            hstall  = vec[k].stall;
            tr_mode = vec[k].stall ? 1 : 0;
            run1(vec[k].root, dn, lat);
            check_vec(k, dn);
            if (k == 0) begin
                b0 = (bdata.size() > 0) ? bdata[0] : 67'h0;
                chk("leaf_int", b0[34:3], 32'd42);
                chk("leaf_latency", lat, 4);
            end
        end
        hstall  = 0;
        tr_mode = 0;

        // Reset while beat 3 of the five-node tree is stalled in EMIT.
        reads.delete();
        bdata.delete();
        blast.delete();
        tr_mode = 2;
        stop_n  = 2;
        @(negedge clk);
        root_d = {16'h1, 1'b1};
        @(posedge clk);
        #1 root_d = '0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (t_v && !t_r && bdata.size() == 2) begin
                found = 1;
                break;
            end
        end
        chk("reach_beat3", found, 1'b1);
        chk("beat3_tdata", t_d, {mem[8'h03], 1'b0});
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_tvalid", t_v, 1'b0);
        chk("mid_rst_req", hq_v, 1'b0);
        chk("mid_rst_root_r", root_r, 1'b1);
        chk("mid_rst_sp", dut.sp_q, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_partial_done", done_d, 1'b0);
        tr_mode = 0;
        run1(16'h1, dn, lat);
        check_vec(1, dn);

        // Overflow on the two-entry stack, then recovery with a leaf root.
        reads2.delete();
        nb2 = 0;
        nl2 = 0;
        done_r2 = 1'b0;
        @(negedge clk);
        root_d2 = {16'h40, 1'b1};
        @(posedge clk);
        #1 root_d2 = '0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (done_d2) begin
                found = 1;
                break;
            end
        end
        chk("ovf_done", found, 1'b1);
        chk("ovf_err", err2, 1'b1);
        chk("ovf_beats", nb2, 0);
        chk("ovf_tlast", nl2, 0);
        chk("ovf_nreads", reads2.size(), 2);
        chk("ovf_rd0", (reads2.size() > 0) ? reads2[0] : 16'hffff, 16'h40);
        chk("ovf_rd1", (reads2.size() > 1) ? reads2[1] : 16'hffff, 16'h41);
        repeat (3) @(negedge clk);
        chk("ovf_done_hold", done_d2, 1'b1);
        done_r2 = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf_done_drop", done_d2, 1'b0);
        chk("ovf_err_sticky", err2, 1'b1);
        chk("ovf_root_r", root_r2, 1'b1);
        nb2 = 0;
        nl2 = 0;
        @(negedge clk);
        root_d2 = {16'h10, 1'b1};
        @(posedge clk);
        #1 root_d2 = '0;
        chk("err_cleared", err2, 1'b0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (done_d2) begin
                found = 1;
                break;
            end
        end
        chk("rec_done", found, 1'b1);
        chk("rec_beats", nb2, 1);
        chk("rec_tlast", nl2, 1);
        chk("rec_int", last2[34:3], 32'd42);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
